// File: rtl/mem_loader.sv
// Byte-stream loader: packs four bytes little-endian into a word and writes
// consecutive words into the 64-entry memory starting at a captured base.
module mem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  done
);

  // Handshake: a byte transfers on a posedge where byte_valid and byte_ready
  // are both high; byte_data must be held stable until that edge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   words_left;
  logic [DATA_WIDTH-1:0] word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      byte_idx         <= '0;
      cur_addr         <= '0;
      words_left       <= '0;
      word             <= '0;
      byte_ready       <= 1'b0;
      mem_write_enable <= 1'b0;
      write_address    <= '0;
      write_data       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      // Pulsed outputs fall by default; each state raises them for one cycle.
      mem_write_enable <= 1'b0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              cur_addr   <= base_addr;
              words_left <= num_words;
              byte_idx   <= '0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              state      <= COLLECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        COLLECT: begin
          if (byte_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              // The final byte goes straight into write_data alongside the
              // three lanes already held, so the write needs no extra cycle.
              write_data       <= {byte_data, word[DATA_WIDTH-9:0]};
              write_address    <= cur_addr;
              mem_write_enable <= 1'b1;
              byte_ready       <= 1'b0;
              state            <= WRITE;
            end
          end
        end
        WRITE: begin
          if (words_left == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            words_left <= words_left - 1'b1;
            cur_addr   <= cur_addr + 1'b1;
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program/data loader that sits directly upstream of the 64 x 32-bit `memory` block and drives its write port. It accepts a byte stream over a valid/ready handshake and assembles four bytes little-endian into one word. It then issues a single-cycle write into consecutive memory addresses starting at a programmed base. The testbench and boot path use it to fill memory before execution, instead of poking `mem_write_enable`/`write_address`/`write_data` by hand.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: memory address width; must match `memory`.
- `DATA_WIDTH`, 32: word width; fixed at 4 bytes.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load; sampled only in IDLE.
- `base_addr`  in  6  first word address, captured on accepted `start`.
- `num_words`  in  7  words to load, 0..64, captured on accepted `start`.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_write_enable`  out  1  to `memory.mem_write_enable`.
- `write_address`  out  6  to `memory.write_address`.
- `write_data`  out  32  to `memory.write_data`.
- `busy`  out  1  high in COLLECT and WRITE.
- `done`  out  1  one-cycle pulse at load completion.

## Operation
- **States:** IDLE, COLLECT, WRITE, DONE. Reset puts the FSM in IDLE.
- **IDLE:**
  - `start`=1 and `num_words`!=0: capture `base_addr` into `cur_addr` and `num_words` into `words_left`, clear `byte_idx`, go to COLLECT.
  - `start`=1 and `num_words`=0: go to DONE, with no writes.
- **COLLECT:**
  - `byte_ready`=1. A byte is accepted when `byte_valid`&`byte_ready`.
  - The byte goes into lane `byte_idx`: idx 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
  - `byte_idx` increments by 1, wrapping mod 4.
  - Acceptance with `byte_idx`=3 goes to WRITE.
- **WRITE:** lasts exactly one cycle.
  - `mem_write_enable`=1, `write_address`=`cur_addr`, `write_data`=assembled word, `byte_ready`=0.
  - Next state: DONE if `words_left`=1. Otherwise `words_left`-1, `cur_addr`+1 (mod 64), and back to COLLECT.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Address wrap:** `cur_addr` 63 + 1 wraps to 0. A 64-word load from any base writes every location exactly once.
- **`start` outside IDLE:** ignored. Captured parameters do not change mid-load.
- **`byte_valid`=0 in COLLECT:** the loader waits indefinitely. There is no timeout, and the partial word is held.
- **Bytes with `byte_ready`=0:** not consumed. Upstream must hold `byte_data` stable until accepted.

## Timing
- **Reset values:** `byte_ready`=0, `mem_write_enable`=0, `write_address`=0, `write_data`=0, `busy`=0, `done`=0. `cur_addr`, `words_left`, `byte_idx` and the word register are cleared.
- **Reset mid-operation:** the partial word is discarded. No write is issued in the reset cycle or after it. The FSM is in IDLE on the cycle after reset deasserts.
- **Output timing:** all outputs are registered or decoded from registered state only. There is no combinational path from `byte_valid`/`start` to any output.
- **Throughput:** with `byte_valid` held high, each word costs 5 cycles (4 COLLECT + 1 WRITE). An N-word load takes 1 (start) + 5N + 1 (DONE) cycles from `start` to the `done` pulse.
- **Write commit:** `memory` commits on the posedge that ends the WRITE cycle. The word is readable via `read_address1`/`read_address2` on the following cycle.
- **Write-enable width:** `mem_write_enable` is never high for more than one consecutive cycle.
- **Idle outputs:** `write_address`/`write_data` may hold their last values when `mem_write_enable`=0.

## Test plan
- **Single word:** reset 2 cycles; `start` with `base_addr`=0, `num_words`=1; bytes 05,00,00,00 back-to-back -> one write pulse, addr 0, data 32'h00000005. `done` follows 1 cycle later, and `read_data1`@RA1=0 reads 32'b0101.
- **Two words:** `start` with base 1, `num_words`=2; bytes 09,00,00,00,EF,BE,AD,DE -> writes addr1=32'h00000009, then addr2=32'hDEADBEEF, 5 cycles apart; `busy` high throughout.
- **Wrap-around:** base 63, `num_words`=2, bytes 11..14, 21..24 -> addr 63=32'h14131211, addr 0=32'h24232221; no write to 1.
- **Backpressure gaps:** `byte_valid` toggling 1,0,0,1,1,0,1 with bytes AA,BB,CC,DD -> exactly one write 32'hDDCCBBAA; `byte_ready` is 0 during WRITE; `start` pulsed mid-load is ignored.
- **Zero length:** `num_words`=0 -> `done` 1 cycle after `start`, `mem_write_enable` never asserts, `byte_ready` stays 0.
- **Reset mid-load:** `reset` asserted after 2 of 4 bytes -> no write ever issued, all outputs at reset values. A subsequent 1-word load to addr 5 works normally.
